// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx round-robin arbiter.
// Optional burst lock is enabled by defining UART_ARB_LOCK_EN.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE
  } arb_state_t;

  localparam int MAX_REQ = 8;

  function automatic logic [2:0] oh2idx(
    input logic [MAX_REQ-1:0] oh
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request
// after ptr, searching upward with wrap.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             valid
);

  logic             hit;
  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    hit    = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N);
      if (!hit && req[idx]) begin
        winner[idx] = 1'b1;
        hit         = 1'b1;
      end
    end
    valid = hit;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ requesters.
// Define UART_ARB_LOCK_EN to add the req_lock burst-lock input.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int TIMEOUT   = 200000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]           req_lock,
`endif
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         tx_start,
  output logic [DATA_BITS-1:0]         tx_data,
  output logic                         tx_en,
  output logic                         tx_rst,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic                         arb_busy,
  output logic                         timeout_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);

  arb_state_t state, state_n;

  logic [PTR_W-1:0]     ptr, ptr_n;
  logic [WD_W-1:0]      wd;
  logic [NUM_REQ-1:0]   pick_oh;
  logic                 pick_vld;
  logic [NUM_REQ-1:0]   sel_oh;
  logic [DATA_BITS-1:0] sel_data;
  logic [PTR_W-1:0]     owner_idx;
  logic                 wd_hit;
  logic                 relock;

  logic [NUM_REQ-1:0]   nxt_gnt;
  logic [NUM_REQ-1:0]   nxt_ack;
  logic [NUM_REQ-1:0]   nxt_done;
  logic                 nxt_start;
  logic [DATA_BITS-1:0] nxt_data;
  logic                 nxt_txrst;
  logic                 nxt_terr;

  logic unused_busy;
  assign unused_busy = tx_busy;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_oh),
    .valid  (pick_vld)
  );

  assign wd_hit    = (wd == WD_W'(TIMEOUT - 1));
  assign owner_idx = PTR_W'(oh2idx(8'(gnt)));

`ifdef UART_ARB_LOCK_EN
  // Locked owner keeps the transmitter; ptr stays put.
  assign relock = en && |(gnt & req_lock & req);
`else
  assign relock = 1'b0;
`endif

  assign sel_oh = (state == IDLE) ? pick_oh : gnt;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_oh[i])
        sel_data = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (en && pick_vld) state_n = START;
      end
      START: begin
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done)     state_n = relock ? START : IDLE;
        else if (wd_hit) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    nxt_gnt   = gnt;
    nxt_ack   = '0;
    nxt_done  = '0;
    nxt_start = 1'b0;
    nxt_data  = tx_data;
    nxt_txrst = 1'b0;
    nxt_terr  = 1'b0;
    ptr_n     = ptr;
    unique case (state)
      IDLE: begin
        if (en && pick_vld) begin
          nxt_gnt   = pick_oh;
          nxt_ack   = pick_oh;
          nxt_start = 1'b1;
          nxt_data  = sel_data;
        end
      end
      START: begin
      end
      WAIT_DONE: begin
        if (tx_done) begin
          nxt_done = gnt;
          if (relock) begin
            nxt_ack   = gnt;
            nxt_start = 1'b1;
            nxt_data  = sel_data;
          end else begin
            nxt_gnt = '0;
            ptr_n   = owner_idx;
          end
        end else if (wd_hit) begin
          nxt_gnt   = '0;
          nxt_txrst = 1'b1;
          nxt_terr  = 1'b1;
          ptr_n     = owner_idx;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt         <= '0;
      req_ack     <= '0;
      req_done    <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      tx_en       <= 1'b0;
      tx_rst      <= 1'b0;
      arb_busy    <= 1'b0;
      timeout_err <= 1'b0;
      ptr         <= PTR_W'(NUM_REQ - 1);
      wd          <= '0;
    end else begin
      gnt         <= nxt_gnt;
      req_ack     <= nxt_ack;
      req_done    <= nxt_done;
      tx_start    <= nxt_start;
      tx_data     <= nxt_data;
      tx_en       <= en;
      tx_rst      <= nxt_txrst;
      arb_busy    <= (state_n != IDLE);
      timeout_err <= nxt_terr;
      ptr         <= ptr_n;
      if (state == WAIT_DONE && state_n == WAIT_DONE)
        wd <= wd + 1'b1;
      else
        wd <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter.
// Lock scenario runs when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [N-1:0]  req;
  logic [N*DB-1:0] req_data;
  logic [N-1:0]  req_lock;
  logic [N-1:0]  req_ack;
  logic [N-1:0]  req_done;
  logic [N-1:0]  gnt;
  logic          tx_start;
  logic [DB-1:0] tx_data;
  logic          tx_en;
  logic          tx_rst;
  logic          tx_busy;
  logic          tx_done;
  logic          arb_busy;
  logic          timeout_err;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ   (N),
    .DATA_BITS (DB),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .req_data    (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .req_ack     (req_ack),
    .req_done    (req_done),
    .gnt         (gnt),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_rst      (tx_rst),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .arb_busy    (arb_busy),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!tx_start && cnt < 40);
    chk("start_seen", 32'(tx_start), 32'd1);
  endtask

  task automatic finish(input int n);
    repeat (n) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  int c;
  int seen;
  int ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    req      = '0;
    req_data = '0;
    req_lock = '0;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;

    // 1: single byte
    do_reset();
    chk("rst_gnt",   32'(gnt), 32'd0);
    chk("rst_ack",   32'(req_ack), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data",  32'(tx_data), 32'd0);
    chk("rst_txen",  32'(tx_en), 32'd0);
    chk("rst_busy",  32'(arb_busy), 32'd0);
    chk("rst_txrst", 32'(tx_rst), 32'd0);
    chk("rst_terr",  32'(timeout_err), 32'd0);
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    wait_start(c);
    chk("t1_lat",  32'(c), 32'd1);
    chk("t1_gnt",  32'(gnt), 32'h1);
    chk("t1_ack",  32'(req_ack), 32'h1);
    chk("t1_data", 32'(tx_data), 32'hA5);
    chk("t1_busy", 32'(arb_busy), 32'd1);
    req = '0;
    tick();
    chk("t1_start_drop", 32'(tx_start), 32'd0);
    chk("t1_ack_drop",   32'(req_ack), 32'd0);
    chk("t1_txen",       32'(tx_en), 32'd1);
    finish(5);
    chk("t1_done",     32'(req_done), 32'h1);
    chk("t1_gnt_clr",  32'(gnt), 32'd0);
    tick();
    chk("t1_done_drop", 32'(req_done), 32'd0);

    // 2: round-robin order
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start(c);
      chk("t2_gap",  32'(c), 32'd1);
      chk("t2_gnt",  32'(gnt), 32'(1 << ord[k]));
      chk("t2_data", 32'(tx_data), 32'(8'h11 * (ord[k] + 1)));
      if (k == 4) req = '0;
      finish(19);
      chk("t2_done", 32'(req_done), 32'(1 << ord[k]));
    end

    // 3: watchdog abort
    do_reset();
    req = 4'b0001;
    wait_start(c);
    req = '0;
    c = 0;
    seen = 0;
    do begin
      tick();
      c++;
      if (req_done != 0) seen++;
    end while (!timeout_err && c < 60);
    chk("t3_lat",    32'(c), 32'd33);
    chk("t3_txrst",  32'(tx_rst), 32'd1);
    chk("t3_gnt",    32'(gnt), 32'd0);
    chk("t3_nodone", 32'(seen), 32'd0);
    tick();
    chk("t3_terr_drop", 32'(timeout_err), 32'd0);
    req = 4'b0011;
    wait_start(c);
    chk("t3_next", 32'(gnt), 32'h2);
    req = '0;
    finish(3);
    req = 4'b0001;
    wait_start(c);
    req = '0;
    repeat (32) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t3_tie_done", 32'(req_done), 32'h1);
    chk("t3_tie_terr", 32'(timeout_err), 32'd0);
    chk("t3_tie_rst",  32'(tx_rst), 32'd0);

    // 4: enable low mid-transfer
    do_reset();
    req = 4'b0001;
    wait_start(c);
    req = 4'b0110;
    repeat (3) tick();
    en = 1'b0;
    tick();
    chk("t4_txen", 32'(tx_en), 32'd0);
    finish(2);
    chk("t4_done", 32'(req_done), 32'h1);
    seen = 0;
    repeat (6) begin
      tick();
      if (tx_start) seen++;
    end
    chk("t4_nostart", 32'(seen), 32'd0);
    chk("t4_idle",    32'(arb_busy), 32'd0);
    en = 1'b1;
    wait_start(c);
    chk("t4_lat", 32'(c), 32'd1);
    chk("t4_gnt", 32'(gnt), 32'h2);
    req = '0;
    finish(2);

    // 5: reset during WAIT_DONE
    do_reset();
    req = 4'b0001;
    wait_start(c);
    req = '0;
    finish(3);
    req = 4'b0010;
    wait_start(c);
    chk("t5_g1", 32'(gnt), 32'h2);
    req = '0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("t5_gnt",   32'(gnt), 32'd0);
    chk("t5_busy",  32'(arb_busy), 32'd0);
    chk("t5_start", 32'(tx_start), 32'd0);
    chk("t5_done",  32'(req_done), 32'd0);
    chk("t5_txrst", 32'(tx_rst), 32'd0);
    chk("t5_txen",  32'(tx_en), 32'd0);
    rst = 1'b0;
    req = 4'b0011;
    wait_start(c);
    chk("t5_next", 32'(gnt), 32'h1);
    req = '0;
    finish(2);

`ifdef UART_ARB_LOCK_EN
    // 6: burst lock
    do_reset();
    req_lock = 4'b0001;
    req = 4'b0011;
    wait_start(c);
    chk("t6_g0", 32'(gnt), 32'h1);
    for (int k = 0; k < 2; k++) begin
      finish(4);
      chk("t6_done",   32'(req_done), 32'h1);
      chk("t6_restart", 32'(tx_start), 32'd1);
      chk("t6_gnt",    32'(gnt), 32'h1);
    end
    req_lock = '0;
    finish(4);
    chk("t6_done3",  32'(req_done), 32'h1);
    chk("t6_nostart", 32'(tx_start), 32'd0);
    wait_start(c);
    chk("t6_g1", 32'(gnt), 32'h2);
    req = '0;
    finish(2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
